fir_mac_seq: RTL and testbench

- Sequential multiply-accumulate engine for a TAPS-tap fixed-point FIR filter. Uses one multiplier, time-shared across the taps.
- Sits directly upstream of the W-bit enabled output register, and drives it through y (data) and done (enable).
- Keeps its own sample delay line, captures the coefficients at start, and produces one saturated sample per accepted start.

---
 rtl/fir_mac_seq.sv | 81 ++++++++
 tb/tb_fir_mac_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: TAPS-tap FIR multiply-accumulate on one shared multiplier, saturated Q(W-FRAC).FRAC output
module fir_mac_seq #(
    parameter int W    = 19,
    parameter int FRAC = 11,
    parameter int TAPS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    x_in,
    input  logic [W*TAPS-1:0] coef,
    output logic [W-1:0]    y,
    output logic            done,
    output logic            busy,
    output logic            ovf
);
    localparam int IW = $clog2(TAPS);
    localparam int AW = 2*W + IW;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t              state_q;
    logic signed [W-1:0] d_q [TAPS];
    logic signed [W-1:0] c_q [TAPS];
    logic signed [2*W-1:0] prod_d;
    logic signed [AW-1:0] acc_q, acc_d, r_d;
    logic [IW-1:0]       idx_q;
    logic [W-1:0]        y_q, y_d;
    logic                done_q, busy_q, ovf_q, ovf_d;
    always_comb begin
        prod_d = d_q[idx_q] * c_q[idx_q];
        acc_d  = acc_q + AW'(prod_d);
        r_d    = acc_q >>> FRAC;
        // r fits in W bits only when its bits above W-2 are pure sign copies
        ovf_d  = !(&r_d[AW-1:W-1] || ~|r_d[AW-1:W-1]);
        y_d    = ovf_d ? {r_d[AW-1], {(W-1){~r_d[AW-1]}}} : r_d[W-1:0];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int k = 0; k < TAPS; k++) begin
                d_q[k] <= '0;
                c_q[k] <= '0;
            end
            acc_q  <= '0;
            idx_q  <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    d_q[0] <= x_in;
                    for (int k = 1; k < TAPS; k++) d_q[k] <= d_q[k-1];
                    for (int k = 0; k < TAPS; k++) c_q[k] <= coef[k*W +: W];
                    acc_q   <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q   <= acc_d;
                    idx_q   <= idx_q + IW'(1);
                    state_q <= (idx_q == IW'(TAPS-1)) ? OUT : MAC;
                end
                OUT: begin
                    y_q     <= y_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign y    = y_q;
    assign done = done_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: directed checks of reset, impulse, saturation, truncation, busy rejection and abort
module tb_fir_mac_seq;
    localparam int W = 19;
    localparam int TAPS = 4;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W*TAPS-1:0] coef = '0;
    logic [W-1:0] y;
    logic done, busy, ovf;
    int checks = 0, fails = 0;
    fir_mac_seq #(.W(W), .FRAC(11), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .coef(coef),
        .y(y), .done(done), .busy(busy), .ovf(ovf)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (n < 20 && done !== 1'b1) begin
            tick();
            n++;
        end
    endtask
    task automatic run(input logic [W-1:0] x, output int n);
        x_in = x;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
    endtask
    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1) n++;
        end
    endtask
    int n;
    initial begin
        start = 1'b1;
        tick();
        tick();
        check("rst_y", {13'b0, y}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ovf", {31'b0, ovf}, 0);
        start = 1'b0;
        rst = 1'b1;
        count_dones(8, n);
        check("rst_no_done", n, 0);
        coef = {19'd256, 19'd512, 19'd1024, 19'd2048};
        x_in = 19'd2048;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("imp_busy", {31'b0, busy}, 1);
        wait_done(n);
        check("imp0_lat", n, 5);
        check("imp0_y", {13'b0, y}, 2048);
        check("imp0_ovf", {31'b0, ovf}, 0);
        tick();
        check("imp0_done_pulse", {31'b0, done}, 0);
        check("imp0_y_hold", {13'b0, y}, 2048);
        run(19'd0, n);
        check("imp1_lat", n, 5);
        check("imp1_y", {13'b0, y}, 1024);
        run(19'd0, n);
        check("imp2_y", {13'b0, y}, 512);
        run(19'd0, n);
        check("imp3_lat", n, 5);
        check("imp3_y", {13'b0, y}, 256);
        check("imp3_ovf", {31'b0, ovf}, 0);
        coef = {4{19'd2048}};
        for (int i = 0; i < 4; i++) run(19'(200000), n);
        check("satp_y", {13'b0, y}, 32'h3FFFF);
        check("satp_ovf", {31'b0, ovf}, 1);
        for (int i = 0; i < 4; i++) run(19'(-200000), n);
        check("satn_y", {13'b0, y}, 32'h40000);
        check("satn_ovf", {31'b0, ovf}, 1);
        for (int i = 0; i < 4; i++) run(19'd0, n);
        coef = {19'd0, 19'd0, 19'd0, 19'd1024};
        run(19'(-3), n);
        check("trunc_y", {13'b0, y}, 32'h7FFFE);
        check("trunc_ovf", {31'b0, ovf}, 0);
        for (int i = 0; i < 3; i++) run(19'd0, n);
        coef = {19'd256, 19'd512, 19'd1024, 19'd2048};
        x_in = 19'd2048;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        x_in = 19'd999;
        coef = {4{19'h7FFFF}};
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 2;
        while (n < 20 && done !== 1'b1) begin
            tick();
            n++;
        end
        check("busy_lat", n, 5);
        check("busy_y", {13'b0, y}, 2048);
        count_dones(10, n);
        check("busy_one_done", n, 0);
        coef = {19'd256, 19'd512, 19'd1024, 19'd2048};
        run(19'd0, n);
        check("busy_shift_once", {13'b0, y}, 1024);
        x_in = 19'd5000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("abort_done_low", {31'b0, done}, 0);
        rst = 1'b1;
        check("abort_y", {13'b0, y}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        count_dones(10, n);
        check("abort_no_done", n, 0);
        coef = {4{19'd2048}};
        run(19'd2048, n);
        check("abort_lat", n, 5);
        check("abort_next_y", {13'b0, y}, 2048);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
